// File: rtl/maxi_pkg.sv
// maxi_stream shared types and helpers.
// Values are widened to 64 bits and indices to 32 bits before comparison.
package maxi_pkg;

  localparam int VAL_W = 64;
  localparam int IDX_W = 32;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  // a beats b on a larger value; on equal values the lower index wins
  function automatic logic is_better(
    input logic [VAL_W-1:0] a_val,
    input logic [IDX_W-1:0] a_idx,
    input logic [VAL_W-1:0] b_val,
    input logic [IDX_W-1:0] b_idx,
    input logic             signed_mode
  );
    logic gt;
    if (signed_mode) gt = $signed(a_val) > $signed(b_val);
    else             gt = a_val > b_val;
    return gt || ((a_val == b_val) && (a_idx < b_idx));
  endfunction

endpackage

// File: rtl/maxi_stream_if.sv
// maxi_stream input beat stream and result stream.
// The master drives beats and consumes results.
interface maxi_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int IDX_WIDTH  = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_max;
  logic [IDX_WIDTH-1:0]        out_idx;
  logic [IDX_WIDTH-1:0]        out_count;
  logic                        out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx,
    input  out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx,
    output out_count, out_overflow
  );
endinterface

// File: rtl/maxi_cmp_stage.sv
// One registered level of the max/argmax tree.
// Reduces 2*PAIRS candidates to PAIRS; frozen while en is low.
module maxi_cmp_stage
  import maxi_pkg::*;
#(
  parameter int PAIRS  = 1,
  parameter int DW     = 32,
  parameter int IW     = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [2*PAIRS*DW-1:0] in_val,
  input  logic [2*PAIRS*IW-1:0] in_idx,
  input  logic                  in_vld,
  input  logic                  in_last,
  output logic [PAIRS*DW-1:0]   out_val,
  output logic [PAIRS*IW-1:0]   out_idx,
  output logic                  out_vld,
  output logic                  out_last
);

  logic [PAIRS*DW-1:0] val_q, val_d;
  logic [PAIRS*IW-1:0] idx_q, idx_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;
  logic [PAIRS-1:0]    bsel;

  function automatic logic [VAL_W-1:0] ext(input logic [DW-1:0] v);
    if (SIGNED) return VAL_W'($signed(v));
    return VAL_W'(v);
  endfunction

  always_comb begin
    bsel = '0;
    for (int p = 0; p < PAIRS; p++) begin
      bsel[p] = is_better(
        ext(in_val[(2*p+1)*DW +: DW]), IDX_W'(in_idx[(2*p+1)*IW +: IW]),
        ext(in_val[2*p*DW +: DW]),     IDX_W'(in_idx[2*p*IW +: IW]),
        SIGNED);
    end
  end

  always_comb begin
    val_d  = val_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (en) begin
      vld_d  = in_vld;
      last_d = in_last;
      for (int p = 0; p < PAIRS; p++) begin
        val_d[p*DW +: DW] = bsel[p] ? in_val[(2*p+1)*DW +: DW]
                                    : in_val[2*p*DW +: DW];
        idx_d[p*IW +: IW] = bsel[p] ? in_idx[(2*p+1)*IW +: IW]
                                    : in_idx[2*p*IW +: IW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign out_val  = val_q;
  assign out_idx  = idx_q;
  assign out_vld  = vld_q;
  assign out_last = last_q;

endmodule

// File: rtl/maxi_stream.sv
// Streaming max/argmax reduction: registered lane tree, per-frame
// accumulator and a backpressured result register.
module maxi_stream
  import maxi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int IDX_WIDTH  = 16,
  parameter bit SIGNED     = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  maxi_stream_if.slave  bus
);

  localparam int DW = DATA_WIDTH;
  localparam int IW = IDX_WIDTH;
  localparam int S  = clog2(LANES);
  localparam int NE = 2*LANES - 1;
  localparam int OT = 2*LANES - 2;

  // all tree levels packed back to back: level l starts at 2L - 2(L>>l)
  logic [NE*DW-1:0] tv;
  logic [NE*IW-1:0] ti;
  logic [S:0]       tvld;
  logic [S:0]       tlast;

  logic          en;
  logic [IW-1:0] base_q, base_d;
  logic [DW-1:0] acc_val_q, acc_val_d;
  logic [IW-1:0] acc_idx_q, acc_idx_d;
  logic          acc_vld_q, acc_vld_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_max_q, out_max_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [IW-1:0] out_count_q, out_count_d;
  logic          out_ovf_q, out_ovf_d;

  logic [DW-1:0] t_val, sel_val;
  logic [IW-1:0] t_idx, sel_idx;
  logic          t_vld, t_last, take_t;
  logic [IW:0]   sum;

  function automatic logic [VAL_W-1:0] ext(input logic [DW-1:0] v);
    if (SIGNED) return VAL_W'($signed(v));
    return VAL_W'(v);
  endfunction

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  assign tv[LANES*DW-1:0] = bus.in_data;
  assign tvld[0]          = bus.in_valid;
  assign tlast[0]         = bus.in_last;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign ti[k*IW +: IW] = base_q + IW'(k);
  end

  for (genvar l = 1; l <= S; l++) begin : g_lvl
    localparam int N  = LANES >> l;
    localparam int OI = 2*LANES - 2*(LANES >> (l-1));
    localparam int OO = 2*LANES - 2*N;
    maxi_cmp_stage #(
      .PAIRS(N), .DW(DW), .IW(IW), .SIGNED(SIGNED)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .in_val  (tv[OI*DW +: 2*N*DW]),
      .in_idx  (ti[OI*IW +: 2*N*IW]),
      .in_vld  (tvld[l-1]),
      .in_last (tlast[l-1]),
      .out_val (tv[OO*DW +: N*DW]),
      .out_idx (ti[OO*IW +: N*IW]),
      .out_vld (tvld[l]),
      .out_last(tlast[l])
    );
  end

  assign t_val  = tv[OT*DW +: DW];
  assign t_idx  = ti[OT*IW +: IW];
  assign t_vld  = tvld[S];
  assign t_last = tlast[S];

  always_comb begin
    // accumulator keeps its entry on equal values
    take_t  = !acc_vld_q ||
              is_better(ext(t_val), '0, ext(acc_val_q), '0, SIGNED);
    sel_val = take_t ? t_val : acc_val_q;
    sel_idx = take_t ? t_idx : acc_idx_q;
    sum     = {1'b0, cnt_q} + (IW+1)'(LANES);

    base_d      = base_q;
    acc_val_d   = acc_val_q;
    acc_idx_d   = acc_idx_q;
    acc_vld_d   = acc_vld_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (en && bus.in_valid)
      base_d = bus.in_last ? '0 : base_q + IW'(LANES);

    if (bus.out_ready) out_valid_d = 1'b0;

    if (en && t_vld) begin
      if (t_last) begin
        out_valid_d = 1'b1;
        out_max_d   = sel_val;
        out_idx_d   = sel_idx;
        out_count_d = sum[IW-1:0];
        out_ovf_d   = ovf_q | sum[IW];
        acc_vld_d   = 1'b0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_val_d = sel_val;
        acc_idx_d = sel_idx;
        acc_vld_d = 1'b1;
        cnt_d     = sum[IW-1:0];
        ovf_d     = ovf_q | sum[IW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      acc_val_q   <= '0;
      acc_idx_q   <= '0;
      acc_vld_q   <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      base_q      <= base_d;
      acc_val_q   <= acc_val_d;
      acc_idx_q   <= acc_idx_d;
      acc_vld_q   <= acc_vld_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_max      = out_max_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_maxi_stream.sv
// Directed bench for maxi_stream: unsigned/16-bit, signed and
// 4-bit-index instances fed the same stimulus in lockstep.
module tb_maxi_stream;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_ready;
  int           pass_cnt;
  int           total;

  maxi_stream_if #(.DATA_WIDTH(32), .LANES(4), .IDX_WIDTH(16)) ia ();
  maxi_stream_if #(.DATA_WIDTH(32), .LANES(4), .IDX_WIDTH(16)) ib ();
  maxi_stream_if #(.DATA_WIDTH(32), .LANES(4), .IDX_WIDTH(4))  ic ();

  assign ia.in_valid  = in_valid;
  assign ia.in_data   = in_data;
  assign ia.in_last   = in_last;
  assign ia.out_ready = out_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_data   = in_data;
  assign ib.in_last   = in_last;
  assign ib.out_ready = out_ready;
  assign ic.in_valid  = in_valid;
  assign ic.in_data   = in_data;
  assign ic.in_last   = in_last;
  assign ic.out_ready = out_ready;

  maxi_stream #(.DATA_WIDTH(32), .LANES(4), .IDX_WIDTH(16), .SIGNED(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  maxi_stream #(.DATA_WIDTH(32), .LANES(4), .IDX_WIDTH(16), .SIGNED(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  maxi_stream #(.DATA_WIDTH(32), .LANES(4), .IDX_WIDTH(4), .SIGNED(1'b0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pk(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic send(input logic [127:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (ia.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ia.out_valid !== 1'b1) begin
      total++;
      $display("FAIL wait_result timeout got out_valid=%b exp 1", ia.out_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++; if (ia.out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", ia.out_valid); else pass_cnt++;
    total++; if (ia.out_max !== 32'd0) $display("FAIL rst_max got %0h exp 0", ia.out_max); else pass_cnt++;
    total++; if (ia.out_idx !== 16'd0) $display("FAIL rst_idx got %0d exp 0", ia.out_idx); else pass_cnt++;
    total++; if (ia.out_count !== 16'd0) $display("FAIL rst_count got %0d exp 0", ia.out_count); else pass_cnt++;
    total++; if (ia.out_overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ia.out_overflow); else pass_cnt++;
    total++; if (ia.in_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", ia.in_ready); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int n;
    send(pk(7, 3, 9, 1), 1'b1);
    wait_res(n);
    total++; if (n !== 2) $display("FAIL single_latency got %0d exp 2 edges after accept", n); else pass_cnt++;
    total++; if (ia.out_max !== 32'd9) $display("FAIL single_max got %0d exp 9", ia.out_max); else pass_cnt++;
    total++; if (ia.out_idx !== 16'd2) $display("FAIL single_idx got %0d exp 2", ia.out_idx); else pass_cnt++;
    total++; if (ia.out_count !== 16'd4) $display("FAIL single_count got %0d exp 4", ia.out_count); else pass_cnt++;
    total++; if (ia.out_overflow !== 1'b0) $display("FAIL single_ovf got %b exp 0", ia.out_overflow); else pass_cnt++;
  endtask

  task automatic test_ties;
    int n;
    send(pk(5, 5, 2, 5), 1'b0);
    send(pk(5, 1, 1, 1), 1'b1);
    wait_res(n);
    total++; if (ia.out_max !== 32'd5) $display("FAIL tie1_max got %0d exp 5", ia.out_max); else pass_cnt++;
    total++; if (ia.out_idx !== 16'd0) $display("FAIL tie1_idx got %0d exp 0", ia.out_idx); else pass_cnt++;
    total++; if (ia.out_count !== 16'd8) $display("FAIL tie1_count got %0d exp 8", ia.out_count); else pass_cnt++;
    @(posedge clk);
    #1;
    send(pk(1, 2, 3, 4), 1'b0);
    send(pk(4, 0, 0, 0), 1'b1);
    wait_res(n);
    total++; if (ia.out_max !== 32'd4) $display("FAIL tie2_max got %0d exp 4", ia.out_max); else pass_cnt++;
    total++; if (ia.out_idx !== 16'd3) $display("FAIL tie2_idx got %0d exp 3", ia.out_idx); else pass_cnt++;
  endtask

  task automatic test_signed;
    int n;
    send(pk(32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE), 1'b1);
    wait_res(n);
    total++; if (ib.out_max !== 32'hFFFF_FFFF) $display("FAIL sgn_max got %0h exp ffffffff", ib.out_max); else pass_cnt++;
    total++; if (ib.out_idx !== 16'd0) $display("FAIL sgn_idx got %0d exp 0", ib.out_idx); else pass_cnt++;
    total++; if (ia.out_max !== 32'hFFFF_FFFF) $display("FAIL uns_neg_max got %0h exp ffffffff", ia.out_max); else pass_cnt++;
    total++; if (ia.out_idx !== 16'd0) $display("FAIL uns_neg_idx got %0d exp 0", ia.out_idx); else pass_cnt++;
    @(posedge clk);
    #1;
    send(pk(32'h8000_0000, 1, 0, 0), 1'b1);
    wait_res(n);
    total++; if (ia.out_max !== 32'h8000_0000) $display("FAIL uns_msb_max got %0h exp 80000000", ia.out_max); else pass_cnt++;
    total++; if (ib.out_max !== 32'd1) $display("FAIL sgn_msb_max got %0h exp 1", ib.out_max); else pass_cnt++;
    total++; if (ib.out_idx !== 16'd1) $display("FAIL sgn_msb_idx got %0d exp 1", ib.out_idx); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int  n;
    logic held;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(pk(0, 0, 0, 10), 1'b1);
    send(pk(20, 0, 0, 0), 1'b1);
    wait_res(n);
    total++; if (ia.out_max !== 32'd10) $display("FAIL bp_first_max got %0d exp 10", ia.out_max); else pass_cnt++;
    total++; if (ia.in_ready !== 1'b0) $display("FAIL bp_ready_low got %b exp 0", ia.in_ready); else pass_cnt++;
    held = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ia.out_valid !== 1'b1 || ia.out_max !== 32'd10) held = 1'b0;
    end
    total++; if (held !== 1'b1) $display("FAIL bp_hold got valid=%b max=%0d exp valid=1 max=10", ia.out_valid, ia.out_max); else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total++; if (ia.in_ready !== 1'b1) $display("FAIL bp_ready_high got %b exp 1", ia.in_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (ia.out_valid !== 1'b1) $display("FAIL bp_second_valid got %b exp 1", ia.out_valid); else pass_cnt++;
    total++; if (ia.out_max !== 32'd20) $display("FAIL bp_second_max got %0d exp 20", ia.out_max); else pass_cnt++;
    total++; if (ia.out_idx !== 16'd0) $display("FAIL bp_second_idx got %0d exp 0", ia.out_idx); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (ia.out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", ia.out_valid); else pass_cnt++;
  endtask

  task automatic test_overflow;
    int n;
    repeat (4) send(pk(1, 1, 1, 1), 1'b0);
    send(pk(0, 0, 100, 0), 1'b1);
    wait_res(n);
    total++; if (ic.out_max !== 32'd100) $display("FAIL ovf_max got %0d exp 100", ic.out_max); else pass_cnt++;
    total++; if (ic.out_idx !== 4'd2) $display("FAIL ovf_idx got %0d exp 2", ic.out_idx); else pass_cnt++;
    total++; if (ic.out_count !== 4'd4) $display("FAIL ovf_count got %0d exp 4", ic.out_count); else pass_cnt++;
    total++; if (ic.out_overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", ic.out_overflow); else pass_cnt++;
    total++; if (ia.out_idx !== 16'd18) $display("FAIL wide_idx got %0d exp 18", ia.out_idx); else pass_cnt++;
    total++; if (ia.out_count !== 16'd20) $display("FAIL wide_count got %0d exp 20", ia.out_count); else pass_cnt++;
    @(posedge clk);
    #1;
    send(pk(1, 2, 3, 4), 1'b1);
    wait_res(n);
    total++; if (ic.out_overflow !== 1'b0) $display("FAIL ovf_next_flag got %b exp 0", ic.out_overflow); else pass_cnt++;
    total++; if (ic.out_idx !== 4'd3) $display("FAIL ovf_next_idx got %0d exp 3", ic.out_idx); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n;
    @(posedge clk);
    #1;
    send(pk(50, 0, 0, 0), 1'b0);
    send(pk(0, 60, 0, 0), 1'b0);
    rst_n = 1'b0;
    #1;
    total++; if (ia.out_valid !== 1'b0 || ia.out_max !== 32'd0 || ia.out_idx !== 16'd0 || ia.out_count !== 16'd0 || ia.out_overflow !== 1'b0)
      $display("FAIL midrst_outputs got v=%b max=%0d idx=%0d cnt=%0d ovf=%b exp all 0", ia.out_valid, ia.out_max, ia.out_idx, ia.out_count, ia.out_overflow);
    else pass_cnt++;
    total++; if (ia.in_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", ia.in_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(pk(0, 0, 0, 6), 1'b1);
    wait_res(n);
    total++; if (ia.out_max !== 32'd6) $display("FAIL midrst_max got %0d exp 6", ia.out_max); else pass_cnt++;
    total++; if (ia.out_idx !== 16'd3) $display("FAIL midrst_idx got %0d exp 3", ia.out_idx); else pass_cnt++;
    total++; if (ia.out_count !== 16'd4) $display("FAIL midrst_count got %0d exp 4", ia.out_count); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total     = 0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset;
    test_single;
    test_ties;
    test_signed;
    test_backpressure;
    test_overflow;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
